// File: rtl/data_memory_master.sv
// Single-outstanding initiator for a synchronous data memory: IDLE -> ACCESS -> (CAPTURE) -> RESP.
// Fixed latency (write: response 1 edge after accept, read: 2); the response holds until rsp_ready.
module data_memory_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       xact_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t              state;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [15:0]         count_q;

  // Outputs decode only the state and latched registers; rst_n gates ready so it is low during reset.
  assign req_ready  = rst_n && (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign mem_en     = (state == ACCESS);
  assign mem_wen    = (state == ACCESS) && lat_wr;
  assign mem_addr   = (state == ACCESS) ? lat_addr : '0;
  assign mem_wdata  = ((state == ACCESS) && lat_wr) ? lat_wdata : '0;
  assign xact_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wr    <= req_wr;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            rsp_rdata <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_wr) begin
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata <= mem_rdata;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            count_q <= count_q + 16'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_memory_master.md
DATA_MEMORY_MASTER -- requirements
Module: data_memory_master

Interface
REQ-001 Parameters SHALL be, one per line:
  - ADDR_W, 8, word-address width (256 words).
  - DATA_W, 32, data word width.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  - clk  in  1  single clock; all state updates on posedge.
  - rst_n  in  1  asynchronous, active-low reset.
  - req_valid  in  1  requester presents an access.
  - req_ready  out  1  block can accept an access.
  - req_wr  in  1  1 = write, 0 = read.
  - req_addr  in  ADDR_W  word address.
  - req_wdata  in  DATA_W  write data.
  - rsp_valid  out  1  access complete; rsp_rdata valid for reads.
  - rsp_ready  in  1  requester accepts response.
  - rsp_rdata  out  DATA_W  read data; 0 for writes.
  - mem_en  out  1  data memory chip-enable.
  - mem_wen  out  1  data memory write-enable.
  - mem_addr  out  ADDR_W  data memory address.
  - mem_wdata  out  DATA_W  data memory write bus.
  - mem_rdata  in  DATA_W  data memory registered read bus.
  - xact_count  out  16  completed accesses, wraps 0xFFFF->0.

Function
REQ-003 The block SHALL be the initiator for the synchronous data memory. That memory samples en/wen/addr/data_in on posedge, presents read data on the following edge, and drives 0 on the edge after en=0.
REQ-004 The FSM SHALL have states IDLE, ACCESS, CAPTURE and RESP, encoded in a single state register.
REQ-005 req_ready SHALL be 1 only in IDLE; one access SHALL be outstanding at most.
REQ-006 IDLE: on req_valid&&req_ready at an edge, the block SHALL latch req_wr/req_addr/req_wdata and go to ACCESS; otherwise it stays in IDLE.
REQ-007 ACCESS, one cycle: mem_en=1, mem_wen=latched wr, mem_addr=latched addr, and mem_wdata=latched wdata (write) or 0 (read).
  - Next state: RESP for a write, CAPTURE for a read.
REQ-008 CAPTURE, one cycle: mem_en=0, mem_wen=0; the block SHALL register mem_rdata into rsp_rdata at the closing edge, then go to RESP.
REQ-009 RESP: rsp_valid=1, with rsp_rdata stable, until rsp_valid&&rsp_ready at an edge; then IDLE and xact_count+1.
REQ-010 For a write, rsp_rdata SHALL be 0 in RESP.
REQ-011 Outside ACCESS, mem_en, mem_wen, mem_addr and mem_wdata SHALL all be 0.
REQ-012 mem_* and rsp_* outputs SHALL depend only on registered state (no combinational path from req_* or rsp_ready).
REQ-013 Latency SHALL be fixed, measured from the accept edge E0:
  - Write: rsp_valid high after E0+1.
  - Read: rsp_valid high after E0+2.
  - With rsp_ready held 1, req_ready returns after one further edge.
REQ-014 req_* changes outside IDLE SHALL be ignored; latched values SHALL hold for the whole access.
REQ-015 rsp_ready asserted outside RESP SHALL have no effect.
REQ-016 xact_count SHALL wrap from 0xFFFF to 0x0000 without any flag.

Reset
REQ-017 On rst_n=0, immediately and regardless of clk, the block SHALL enter IDLE with all of the following at 0:
  - rsp_valid, rsp_rdata, mem_en, mem_wen, mem_addr, mem_wdata, xact_count, and the latched request registers.
REQ-018 Reset during ACCESS/CAPTURE/RESP SHALL abort the access: no response, no count increment, mem_en low within the reset assertion.
REQ-019 req_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after deassertion.

Verification
REQ-020 Write then read back: write addr 0x05 data 0xDEADBEEF, then read 0x05.
  - mem_wen=1 for exactly one cycle.
  - Read rsp_rdata=0xDEADBEEF two edges after accept.
  - xact_count=2.
REQ-021 Response backpressure: rsp_ready held 0 for 5 cycles on a read of 0xFF.
  - rsp_valid and rsp_rdata hold steady.
  - req_ready stays 0; a new req_valid is ignored until the handshake.
REQ-022 Back-to-back reads with req_valid and rsp_ready tied 1 to addresses 0x00..0x03: one response every 4 cycles, data in order, mem_en high exactly once per access.
REQ-023 Reset mid-access: assert rst_n=0 during CAPTURE.
  - All outputs 0 asynchronously; no rsp_valid.
  - xact_count=0; req_ready=1 on the first cycle after release.
REQ-024 Counter wrap: preload 0xFFFE completed accesses (or force), then run 2 writes; xact_count reads 0xFFFF, then 0x0000.
